// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// soft-reset counter width and the per-channel release-edge calculation.
package rst_seq_ctrl_pkg;

  localparam int SOFT_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_RELEASING = 2'd1,
    ST_RUN       = 2'd2,
    ST_DONE      = 2'd3
  } rst_seq_state_t;

  // Counted edge (E1 = 1) on which channel k leaves reset.
  function automatic int ch_release_edge(input int k, input int release_clk, input int stagger_clk);
    return release_clk + k * stagger_clk;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer and run timer: staggers NUM_CH domain resets after a
// synchronous reset or soft-reset request, then times a fixed run window.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int NUM_CH            = 4,
  parameter int RELEASE_AFTER_CLK = 2,
  parameter int STAGGER_CLK       = 1,
  parameter int RUN_DURATION_CLK  = 25
) (
  input  logic                  i_clk,
  input  logic                  i_sync_rst,
  input  logic                  i_soft_rst_req,
  output logic [NUM_CH-1:0]     o_ch_rst,
  output logic                  o_all_released,
  output logic                  o_run_done,
  output logic [SOFT_CNT_W-1:0] o_soft_rst_cnt
);

  localparam int T_LAST  = ch_release_edge(NUM_CH - 1, RELEASE_AFTER_CLK, STAGGER_CLK);
  localparam int MAX_CNT = (T_LAST > RUN_DURATION_CLK) ? T_LAST : RUN_DURATION_CLK;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0]      RUN_END  = CNT_W'(RUN_DURATION_CLK);
  localparam logic [SOFT_CNT_W-1:0] SOFT_MAX = {SOFT_CNT_W{1'b1}};

  if (NUM_CH < 1) begin : g_chk_num_ch
    $error("rst_seq_ctrl: NUM_CH must be >= 1");
  end
  if (RELEASE_AFTER_CLK < 1) begin : g_chk_release
    $error("rst_seq_ctrl: RELEASE_AFTER_CLK must be >= 1");
  end
  if (STAGGER_CLK < 0) begin : g_chk_stagger
    $error("rst_seq_ctrl: STAGGER_CLK must be >= 0");
  end
  if (RUN_DURATION_CLK < 1) begin : g_chk_run
    $error("rst_seq_ctrl: RUN_DURATION_CLK must be >= 1");
  end

  rst_seq_state_t   state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             restart_s;
  logic             rel_step_s;
  logic [NUM_CH-1:0] ch_hit_s;
  logic             last_hit_s;
  logic             run_hit_s;
  logic             soft_req_q_r;
  logic             soft_rise_s;

  assign restart_s   = i_sync_rst | i_soft_rst_req;
  assign soft_rise_s = i_soft_rst_req & ~soft_req_q_r;

  // Value the counter takes on the coming edge; release compares look at it
  // so a channel drops on exactly the edge where the count reaches its threshold.
  always_comb begin
    cnt_next_s = cnt_r;
    rel_step_s = 1'b0;
    case (state_r)
      ST_HOLD: begin
        cnt_next_s = CNT_W'(1);
        rel_step_s = 1'b1;
      end
      ST_RELEASING: begin
        cnt_next_s = cnt_r + CNT_W'(1);
        rel_step_s = 1'b1;
      end
      ST_RUN: begin
        cnt_next_s = cnt_r + CNT_W'(1);
        rel_step_s = 1'b0;
      end
      ST_DONE: begin
        cnt_next_s = cnt_r;
        rel_step_s = 1'b0;
      end
      default: begin
        cnt_next_s = cnt_r;
        rel_step_s = 1'b0;
      end
    endcase
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [CNT_W-1:0] T_K = CNT_W'(ch_release_edge(k, RELEASE_AFTER_CLK, STAGGER_CLK));
    assign ch_hit_s[k] = rel_step_s & (cnt_next_s == T_K);
  end

  assign last_hit_s = ch_hit_s[NUM_CH-1];
  assign run_hit_s  = (state_r == ST_RUN) & (cnt_next_s == RUN_END);

  // Sequencer FSM, counter and per-channel reset outputs.
  always_ff @(posedge i_clk) begin
    if (restart_s) begin
      state_r        <= ST_HOLD;
      cnt_r          <= CNT_W'(0);
      o_ch_rst       <= {NUM_CH{1'b1}};
      o_all_released <= 1'b0;
      o_run_done     <= 1'b0;
    end else begin
      o_ch_rst <= o_ch_rst & ~ch_hit_s;
      case (state_r)
        ST_HOLD, ST_RELEASING: begin
          if (last_hit_s) begin
            state_r        <= ST_RUN;
            cnt_r          <= CNT_W'(0);
            o_all_released <= 1'b1;
          end else begin
            state_r <= ST_RELEASING;
            cnt_r   <= cnt_next_s;
          end
        end
        ST_RUN: begin
          cnt_r <= cnt_next_s;
          if (run_hit_s) begin
            state_r    <= ST_DONE;
            o_run_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r        <= ST_HOLD;
          cnt_r          <= CNT_W'(0);
          o_ch_rst       <= {NUM_CH{1'b1}};
          o_all_released <= 1'b0;
          o_run_done     <= 1'b0;
        end
      endcase
    end
  end

  // Soft-reset request counter: counts request rising edges, survives soft resets.
  always_ff @(posedge i_clk) begin
    soft_req_q_r <= i_soft_rst_req;
    if (i_sync_rst) begin
      o_soft_rst_cnt <= {SOFT_CNT_W{1'b0}};
    end else if (soft_rise_s && (o_soft_rst_cnt != SOFT_MAX)) begin
      o_soft_rst_cnt <= o_soft_rst_cnt + SOFT_CNT_W'(1);
    end else begin
      o_soft_rst_cnt <= o_soft_rst_cnt;
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: default configuration plus a
// zero-stagger 3-channel instance, both compared against an edge-count model.
module tb_rst_seq_ctrl;

  localparam int A_N = 4, A_REL = 2, A_STG = 1, A_RUN = 25;
  localparam int B_N = 3, B_REL = 2, B_STG = 0, B_RUN = 25;

  logic       i_clk = 1'b0;
  logic       i_sync_rst;
  logic       i_soft_rst_req;
  logic [3:0] a_ch_rst;
  logic       a_all_rel;
  logic       a_run_done;
  logic [7:0] a_soft_cnt;
  logic [2:0] b_ch_rst;
  logic       b_all_rel;
  logic       b_run_done;
  logic [7:0] b_soft_cnt;

  int checks = 0;
  int errors = 0;
  int e_cnt;
  int m_soft_cnt;
  bit m_prev_req;

  always #5 i_clk = ~i_clk;

  rst_seq_ctrl #(
    .NUM_CH(A_N), .RELEASE_AFTER_CLK(A_REL), .STAGGER_CLK(A_STG), .RUN_DURATION_CLK(A_RUN)
  ) dut_a (
    .i_clk(i_clk), .i_sync_rst(i_sync_rst), .i_soft_rst_req(i_soft_rst_req),
    .o_ch_rst(a_ch_rst), .o_all_released(a_all_rel), .o_run_done(a_run_done),
    .o_soft_rst_cnt(a_soft_cnt)
  );

  rst_seq_ctrl #(
    .NUM_CH(B_N), .RELEASE_AFTER_CLK(B_REL), .STAGGER_CLK(B_STG), .RUN_DURATION_CLK(B_RUN)
  ) dut_b (
    .i_clk(i_clk), .i_sync_rst(i_sync_rst), .i_soft_rst_req(i_soft_rst_req),
    .o_ch_rst(b_ch_rst), .o_all_released(b_all_rel), .o_run_done(b_run_done),
    .o_soft_rst_cnt(b_soft_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t e=%0d)", tag, obs, exp_v, $time, e_cnt);
    end
  endtask

  // Channel k is still in reset while fewer than rel + k*stg quiet edges have elapsed.
  function automatic logic [31:0] exp_ch(input int ev, input int n, input int rel, input int stg);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 0; k < n; k++) v[k] = (ev < rel + k * stg);
    return v;
  endfunction

  task automatic cycle(input bit s, input bit q);
    i_sync_rst     = s;
    i_soft_rst_req = q;
    @(posedge i_clk);
    if (s || q) e_cnt = 0;
    else if (e_cnt < 100000) e_cnt++;
    if (s) m_soft_cnt = 0;
    else if (q && !m_prev_req && m_soft_cnt < 255) m_soft_cnt++;
    m_prev_req = q;
    #1;
    chk("a_ch_rst",   {28'd0, a_ch_rst},   exp_ch(e_cnt, A_N, A_REL, A_STG));
    chk("a_all_rel",  {31'd0, a_all_rel},  {31'd0, e_cnt >= A_REL + (A_N - 1) * A_STG});
    chk("a_run_done", {31'd0, a_run_done}, {31'd0, e_cnt >= A_REL + (A_N - 1) * A_STG + A_RUN});
    chk("a_soft_cnt", {24'd0, a_soft_cnt}, m_soft_cnt);
    chk("b_ch_rst",   {29'd0, b_ch_rst},   exp_ch(e_cnt, B_N, B_REL, B_STG));
    chk("b_all_rel",  {31'd0, b_all_rel},  {31'd0, e_cnt >= B_REL + (B_N - 1) * B_STG});
    chk("b_run_done", {31'd0, b_run_done}, {31'd0, e_cnt >= B_REL + (B_N - 1) * B_STG + B_RUN});
    chk("b_soft_cnt", {24'd0, b_soft_cnt}, m_soft_cnt);
  endtask

  task automatic run(input bit s, input bit q, input int n);
    for (int i = 0; i < n; i++) cycle(s, q);
  endtask

  initial begin
    int seg;
    int len;
    e_cnt          = 0;
    m_soft_cnt     = 0;
    m_prev_req     = 1'b0;
    i_sync_rst     = 1'b1;
    i_soft_rst_req = 1'b0;

    // Power-up: staggered release and run window on both instances.
    run(1'b1, 1'b0, 3);
    run(1'b0, 1'b0, 35);

    // Soft pulse mid-release, then full sequence again.
    run(1'b1, 1'b0, 1);
    run(1'b0, 1'b0, 3);
    run(1'b0, 1'b1, 1);
    run(1'b0, 1'b0, 40);

    // Long soft request while done: counts once, sequence repeats.
    run(1'b0, 1'b1, 5);
    run(1'b0, 1'b0, 40);

    // Saturation of the soft-reset counter, then cleared by sync reset.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
    end
    run(1'b1, 1'b0, 1);
    run(1'b0, 1'b0, 2);

    // Counter at 7, then both resets on the same edge.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
    end
    run(1'b1, 1'b1, 1);
    run(1'b0, 1'b0, 3);

    // Randomized segments.
    for (int i = 0; i < 80; i++) begin
      seg = int'($urandom_range(0, 9));
      if (seg <= 5) begin
        len = int'($urandom_range(1, 40));
        run(1'b0, 1'b0, len);
      end else if (seg <= 7) begin
        len = int'($urandom_range(1, 6));
        run(1'b0, 1'b1, len);
      end else if (seg == 8) begin
        len = int'($urandom_range(1, 3));
        run(1'b1, 1'b0, len);
      end else begin
        len = int'($urandom_range(1, 10));
        for (int j = 0; j < len; j++) begin
          cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
        end
      end
    end
    run(1'b0, 1'b0, 35);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
